// File: rtl/imm_ext_pkg.sv
// Shared definitions for the decode-stage immediate unit: opcode values,
// extension-mode encoding and the skid-buffer state encoding.
package imm_ext_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [2:0] {
        EXT_NONE   = 3'd0,
        EXT_SIGN   = 3'd1,
        EXT_ZERO   = 3'd2,
        EXT_UPPER  = 3'd3,
        EXT_BRANCH = 3'd4
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational opcode decode and INW->OUTW immediate extension.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 32
) (
    input  logic [5:0]      opcode_i,
    input  logic [INW-1:0]  field_i,
    output ext_mode_e       mode_o,
    output logic [OUTW-1:0] imm_o,
    output logic            illegal_o
);

    logic [OUTW-1:0] sext;
    assign sext = {{(OUTW-INW){field_i[INW-1]}}, field_i};

    // NOTE: every output of a combinational block gets a default first, otherwise unlisted paths infer latches.
    always_comb begin
        mode_o    = EXT_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: mode_o = EXT_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:                          mode_o = EXT_ZERO;
            OP_LUI:                                            mode_o = EXT_UPPER;
            OP_BEQ, OP_BNE:                                    mode_o = EXT_BRANCH;
            OP_RTYPE, OP_J, OP_JAL:                            mode_o = EXT_NONE;
            default:                                           illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (mode_o)
            EXT_SIGN:   imm_o = sext;
            EXT_ZERO:   imm_o = {{(OUTW-INW){1'b0}}, field_i};
            EXT_UPPER:  imm_o = {field_i, {(OUTW-INW){1'b0}}};
            EXT_BRANCH: imm_o = sext << 2;  // top bits shifted out are dropped
            default:    imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Decode-stage immediate unit: extends on push and buffers results in a
// 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTW-1:0] out_imm,
    output logic [2:0]      out_mode,
    output logic            out_illegal
);

    ext_mode_e       new_mode;
    logic [OUTW-1:0] new_imm;
    logic            new_illegal;

    imm_extend_unit #(.INW(INW), .OUTW(OUTW)) u_ext (
        .opcode_i  (in_instr[31:26]),
        .field_i   (in_instr[INW-1:0]),
        .mode_o    (new_mode),
        .imm_o     (new_imm),
        .illegal_o (new_illegal)
    );

    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[25:INW];

    buf_state_e      state_q, state_d;
    logic            in_ready_q;
    logic [OUTW-1:0] head_imm_q, tail_imm_q;
    ext_mode_e       head_mode_q, tail_mode_q;
    logic            head_ill_q, tail_ill_q;

    logic push, pop;
    logic load_head_new, load_head_tail, load_tail;

    assign out_valid   = (state_q != ST_EMPTY);
    assign in_ready    = in_ready_q;
    assign out_imm     = head_imm_q;
    assign out_mode    = head_mode_q;
    assign out_illegal = head_ill_q;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) begin
                    state_d       = ST_ONE;
                    load_head_new = 1'b1;
                end
                ST_ONE: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_d   = ST_TWO;
                        load_tail = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (pop) begin
                    state_d        = ST_ONE;
                    load_head_tail = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            // NOTE: the two buffer entries are plain flops and are cleared so out_imm reads zero after reset.
            head_imm_q  <= '0;
            head_mode_q <= EXT_NONE;
            head_ill_q  <= 1'b0;
            tail_imm_q  <= '0;
            tail_mode_q <= EXT_NONE;
            tail_ill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_head_new) begin
                head_imm_q  <= new_imm;
                head_mode_q <= new_mode;
                head_ill_q  <= new_illegal;
            end else if (load_head_tail) begin
                head_imm_q  <= tail_imm_q;
                head_mode_q <= tail_mode_q;
                head_ill_q  <= tail_ill_q;
            end
            if (load_tail) begin
                tail_imm_q  <= new_imm;
                tail_mode_q <= new_mode;
                tail_ill_q  <= new_illegal;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed plan cases plus randomized
// traffic checked against a queue-based reference model.
module tb_imm_ext_stage;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  mode;
        logic        ill;
    } res_t;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, out_imm;
    logic [2:0]  out_mode;

    int   vectors = 0;
    int   miscompares = 0;
    res_t model_q[$];

    imm_ext_stage #(.INW(16), .OUTW(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_mode(out_mode), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extension computed directly from the opcode table with integer arithmetic.
    function automatic res_t ref_ext(input logic [31:0] instr);
        res_t r;
        int   s;
        logic [5:0] op;
        op = instr[31:26];
        s  = int'($signed(instr[15:0]));
        r  = '0;
        case (op)
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin r.mode = 3'd1; r.imm = 32'(s); end
            6'h0C, 6'h0D, 6'h0E: begin r.mode = 3'd2; r.imm = 32'(instr[15:0]); end
            6'h0F:               begin r.mode = 3'd3; r.imm = 32'(instr[15:0]) * 32'd65536; end
            6'h04, 6'h05:        begin r.mode = 3'd4; r.imm = 32'(s * 4); end
            6'h00, 6'h02, 6'h03: r.mode = 3'd0;
            default:             r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Applies one cycle of stimulus and advances the model; leaves time at posedge+1.
    task automatic tick(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
        logic do_push, do_pop;
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        do_push   = v && (model_q.size() < 2);
        do_pop    = rdy && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(ref_ext(instr));
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++; if (out_imm !== 32'h0) begin miscompares++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        vectors++; if (out_mode !== 3'd0 || out_illegal !== 1'b0) begin
            miscompares++; $display("FAIL reset_mode_ill got %0d/%0b want 0/0", out_mode, out_illegal);
        end
    endtask

    task automatic test_modes();
        logic [31:0] instrs [11] = '{32'h2000FFFF, 32'h34008000, 32'h3C001234, 32'h1000FFFE,
                                     32'h00000020, 32'hFC001234, 32'h8C008000, 32'h14007FFF,
                                     32'h3800FFFF, 32'h08001234, 32'h04001234};
        logic [31:0] imms [11]   = '{32'hFFFFFFFF, 32'h00008000, 32'h12340000, 32'hFFFFFFF8,
                                     32'h0, 32'h0, 32'hFFFF8000, 32'h0001FFFC,
                                     32'h0000FFFF, 32'h0, 32'h0};
        logic [2:0]  modes [11]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1, 3'd4, 3'd2, 3'd0, 3'd0};
        logic        ills [11]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, instrs[i], 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_imm !== imms[i] || out_mode !== modes[i] || out_illegal !== ills[i]) begin
                miscompares++;
                $display("FAIL mode_case%0d got v=%0b imm=%h mode=%0d ill=%0b want v=1 imm=%h mode=%0d ill=%0b",
                         i, out_valid, out_imm, out_mode, out_illegal, imms[i], modes[i], ills[i]);
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mode_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        tick(1'b1, 32'h20000005, 1'b0, 1'b0);
        tick(1'b1, 32'h30000007, 1'b0, 1'b0);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full got %0b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h20000009, 1'b0, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_imm !== 32'd5 || in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold%0d got v=%0b imm=%h rdy=%0b want v=1 imm=5 rdy=0", i, out_valid, out_imm, in_ready);
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'd7 || out_mode !== 3'd2 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_second got v=%0b imm=%h mode=%0d rdy=%0b want v=1 imm=7 mode=2 rdy=1", out_valid, out_imm, out_mode, in_ready);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] instr;
        res_t exp;
        tick(1'b1, 32'h20000100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            instr = {6'h08, 10'h0, 16'(i * 3 + 1)};
            tick(1'b1, instr, 1'b1, 1'b0);
            exp = ref_ext(instr);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== exp.imm) begin
                miscompares++; $display("FAIL stream%0d got v=%0b rdy=%0b imm=%h want v=1 rdy=1 imm=%h", i, out_valid, in_ready, out_imm, exp.imm);
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h20000011, 1'b0, 1'b0);
        tick(1'b1, 32'h20000022, 1'b0, 1'b0);
        tick(1'b1, 32'h20000033, 1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_two got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
        tick(1'b1, 32'h20000044, 1'b0, 1'b0);
        tick(1'b1, 32'h20000055, 1'b1, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_one got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
        tick(1'b1, 32'h20000066, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h66) begin
            miscompares++; $display("FAIL flush_after got v=%0b imm=%h want v=1 imm=00000066", out_valid, out_imm);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        tick(1'b1, 32'h2000FFFF, 1'b0, 1'b0);
        tick(1'b1, 32'h3C00ABCD, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_mode !== 3'd0 || out_illegal !== 1'b0) begin
            miscompares++; $display("FAIL async_reset got v=%0b rdy=%0b imm=%h mode=%0d ill=%0b want 0/1/0/0/0",
                                    out_valid, in_ready, out_imm, out_mode, out_illegal);
        end
        #2 rst_n = 1'b1;
        tick(1'b1, 32'h20000001, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'd1 || out_mode !== 3'd1) begin
            miscompares++; $display("FAIL post_reset_addi got v=%0b imm=%h mode=%0d want v=1 imm=1 mode=1", out_valid, out_imm, out_mode);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0]  ops [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                  6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        logic [31:0] r;
        logic [5:0]  op;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom();
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 15)];
            tick(1'($urandom_range(0, 3) != 0), {op, r[25:0]}, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
            vectors++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
                miscompares++; $display("FAIL rand%0d_hs got v=%0b rdy=%0b want v=%0b rdy=%0b",
                                        i, out_valid, in_ready, model_q.size() > 0, model_q.size() < 2);
            end else if (model_q.size() > 0) begin
                vectors++;
                if (out_imm !== model_q[0].imm || out_mode !== model_q[0].mode || out_illegal !== model_q[0].ill) begin
                    miscompares++; $display("FAIL rand%0d_head got imm=%h mode=%0d ill=%0b want imm=%h mode=%0d ill=%0b",
                                            i, out_imm, out_mode, out_illegal, model_q[0].imm, model_q[0].mode, model_q[0].ill);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
